rr_bus_arbiter4: RTL and testbench

- Round-robin arbiter that shares one 32-bit datapath between four requesters.
- Generates the 2-bit select for the shared 32-bit 4:1 mux and registers the muxed data into an output stage with valid/ready handshake.
- Grants are held for multi-beat bursts, ended by LAST or by a hold limit.
- Sits between four data producers (e.g. register-file read ports, memory, ALU result) and a single downstream consumer.

---
 rtl/rr_bus_arbiter4_if.sv | 37 +++
 rtl/rr_bus_arbiter4.sv | 147 ++++++++++++++
 tb/tb_rr_bus_arbiter4.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/rr_bus_arbiter4_if.sv
// ============================================================================
// Module   : rr_bus_arbiter4_if
// Brief    : Bundle of request, data, grant and output-stage handshake signals
//            for the four-way round-robin bus arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rr_bus_arbiter4_if #(
    parameter int DATA_WIDTH = 32
);
    logic [3:0]            REQ;
    logic [3:0]            LAST;
    logic [DATA_WIDTH-1:0] D0;
    logic [DATA_WIDTH-1:0] D1;
    logic [DATA_WIDTH-1:0] D2;
    logic [DATA_WIDTH-1:0] D3;
    logic [3:0]            GNT;
    logic [3:0]            ACK;
    logic [1:0]            SEL;
    logic [DATA_WIDTH-1:0] Y;
    logic                  Y_VALID;
    logic                  Y_READY;

    // master: the arbiter itself; slave: the producers and downstream consumer
    modport master (
        input  REQ, LAST, D0, D1, D2, D3, Y_READY,
        output GNT, ACK, SEL, Y, Y_VALID
    );

    modport slave (
        output REQ, LAST, D0, D1, D2, D3, Y_READY,
        input  GNT, ACK, SEL, Y, Y_VALID
    );
endinterface

`default_nettype wire

// File: rtl/rr_bus_arbiter4.sv
// ============================================================================
// Module   : rr_bus_arbiter4
// Brief    : Four-requester round-robin arbiter with burst hold, shared 4:1
//            data mux select and a registered valid/ready output stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_bus_arbiter4 #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = 8
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    rr_bus_arbiter4_if.master bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_ptr;
    logic [1:0]            w_ptr_nxt;
    logic [1:0]            r_sel;
    logic [1:0]            w_sel_nxt;
    logic [3:0]            r_gnt;
    logic [3:0]            w_gnt_nxt;
    logic [7:0]            r_hold_cnt;
    logic [7:0]            w_hold_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_y;
    logic [DATA_WIDTH-1:0] w_y_nxt;
    logic                  r_y_valid;
    logic                  w_y_valid_nxt;

    logic                  w_pick_valid;
    logic [1:0]            w_pick_idx;
    logic                  w_open;
    logic                  w_owner_req;
    logic                  w_take;
    logic                  w_final;
    logic [DATA_WIDTH-1:0] w_mux_data;

    // Rotating search: later iterations override, so ptr+1 ends up highest priority
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = r_ptr;
        for (int i = 4; i >= 1; i--) begin
            if (bus.REQ[r_ptr + 2'(i)]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = r_ptr + 2'(i);
            end
        end
    end

    always_comb begin
        w_mux_data = bus.D0;
        case (r_sel)
            2'd0:    w_mux_data = bus.D0;
            2'd1:    w_mux_data = bus.D1;
            2'd2:    w_mux_data = bus.D2;
            default: w_mux_data = bus.D3;
        endcase
    end

    assign w_open      = !r_y_valid || bus.Y_READY;
    assign w_owner_req = bus.REQ[r_sel];
    assign w_take      = (r_state == ST_BUSY) && w_owner_req && w_open;
    assign w_final     = bus.LAST[r_sel] || (r_hold_cnt == c_hold_last);

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_sel_nxt      = r_sel;
        w_gnt_nxt      = r_gnt;
        w_hold_cnt_nxt = r_hold_cnt;
        w_y_nxt        = r_y;
        w_y_valid_nxt  = r_y_valid;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt    = ST_BUSY;
                    w_gnt_nxt      = 4'b0001 << w_pick_idx;
                    w_sel_nxt      = w_pick_idx;
                    w_hold_cnt_nxt = 8'd0;
                end
            end
            ST_BUSY: begin
                if (w_take) begin
                    w_hold_cnt_nxt = r_hold_cnt + 8'd1;
                end
                // LAST and hold limit on one beat collapse into a single release
                if ((w_take && w_final) || !w_owner_req) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 4'b0000;
                    w_ptr_nxt   = r_sel;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
            end
        endcase

        // Output stage drains on its own, independent of the arbiter state
        if (w_take) begin
            w_y_nxt       = w_mux_data;
            w_y_valid_nxt = 1'b1;
        end else if (bus.Y_READY) begin
            w_y_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 2'd3;
            r_sel      <= 2'd0;
            r_gnt      <= 4'b0000;
            r_hold_cnt <= 8'd0;
            r_y        <= '0;
            r_y_valid  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_sel      <= w_sel_nxt;
            r_gnt      <= w_gnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_y        <= w_y_nxt;
            r_y_valid  <= w_y_valid_nxt;
        end
    end

    assign bus.GNT     = r_gnt;
    assign bus.SEL     = r_sel;
    assign bus.ACK     = w_take ? (4'b0001 << r_sel) : 4'b0000;
    assign bus.Y       = r_y;
    assign bus.Y_VALID = r_y_valid;

endmodule

`default_nettype wire

// File: tb/tb_rr_bus_arbiter4.sv
// ============================================================================
// Module   : tb_rr_bus_arbiter4
// Brief    : Directed self-checking bench for rr_bus_arbiter4.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_bus_arbiter4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rr_bus_arbiter4_if #(.DATA_WIDTH(32)) bus ();

    rr_bus_arbiter4 #(
        .DATA_WIDTH(32),
        .MAX_HOLD  (8)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.master)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.REQ = 4'b0000; bus.LAST = 4'b0000; bus.Y_READY = 1'b1;
        bus.D0 = '0; bus.D1 = '0; bus.D2 = '0; bus.D3 = '0;
        tick(); tick();
        rst = 1'b0;
        total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", bus.GNT); end
        total++; if (bus.ACK !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", bus.ACK); end
        total++; if (bus.SEL !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", bus.SEL); end
        total++; if (bus.Y !== 32'h0) begin bad++; $display("FAIL reset_y got=%h want=0", bus.Y); end
        total++; if (bus.Y_VALID !== 1'b0) begin bad++; $display("FAIL reset_yvalid got=%b want=0", bus.Y_VALID); end
    endtask

    task automatic test_single;
        bus.REQ = 4'b0001; bus.LAST = 4'b0001; bus.D0 = 32'hA5A5_0001;
        #1;
        total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL single_idle_gnt got=%b want=0000", bus.GNT); end
        tick();
        total++; if (bus.GNT !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b want=0001", bus.GNT); end
        total++; if (bus.SEL !== 2'd0) begin bad++; $display("FAIL single_sel got=%0d want=0", bus.SEL); end
        total++; if (bus.ACK !== 4'b0001) begin bad++; $display("FAIL single_ack got=%b want=0001", bus.ACK); end
        tick();
        bus.REQ = 4'b0000;
        total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL single_release got=%b want=0000", bus.GNT); end
        total++; if (bus.Y !== 32'hA5A5_0001) begin bad++; $display("FAIL single_y got=%h want=a5a50001", bus.Y); end
        total++; if (bus.Y_VALID !== 1'b1) begin bad++; $display("FAIL single_yvalid got=%b want=1", bus.Y_VALID); end
        tick();
        total++; if (bus.Y_VALID !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", bus.Y_VALID); end
    endtask

    task automatic test_rotation;
        logic [3:0]  exp_gnt;
        logic [1:0]  exp_sel;
        logic [31:0] exp_y;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.REQ = 4'b1111; bus.LAST = 4'b1111;
        bus.D0 = 32'h1000_0000; bus.D1 = 32'h1000_0001; bus.D2 = 32'h1000_0002; bus.D3 = 32'h1000_0003;
        for (int i = 0; i < 5; i++) begin
            exp_sel = 2'(i % 4);
            exp_gnt = 4'b0001 << exp_sel;
            exp_y   = 32'h1000_0000 | 32'(i % 4);
            tick();
            total++; if (bus.GNT !== exp_gnt) begin bad++; $display("FAIL rot_gnt[%0d] got=%b want=%b", i, bus.GNT, exp_gnt); end
            total++; if (bus.SEL !== exp_sel) begin bad++; $display("FAIL rot_sel[%0d] got=%0d want=%0d", i, bus.SEL, exp_sel); end
            total++; if (bus.ACK !== exp_gnt) begin bad++; $display("FAIL rot_ack[%0d] got=%b want=%b", i, bus.ACK, exp_gnt); end
            tick();
            total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL rot_gap[%0d] got=%b want=0000", i, bus.GNT); end
            total++; if (bus.ACK !== 4'b0000) begin bad++; $display("FAIL rot_idle_ack[%0d] got=%b want=0000", i, bus.ACK); end
            total++; if (bus.Y !== exp_y) begin bad++; $display("FAIL rot_y[%0d] got=%h want=%h", i, bus.Y, exp_y); end
        end
        bus.REQ = 4'b0000; bus.LAST = 4'b0000;
    endtask

    task automatic test_hold_limit;
        logic [31:0] exp_y;
        logic [3:0]  exp_gnt;
        bus.REQ = 4'b0100;
        tick();
        total++; if (bus.GNT !== 4'b0100) begin bad++; $display("FAIL hold_gnt got=%b want=0100", bus.GNT); end
        total++; if (bus.SEL !== 2'd2) begin bad++; $display("FAIL hold_sel got=%0d want=2", bus.SEL); end
        for (int b = 0; b < 8; b++) begin
            exp_y   = 32'h2222_0000 + 32'(b);
            exp_gnt = (b == 7) ? 4'b0000 : 4'b0100;
            bus.D2  = exp_y;
            if (b == 1) bus.REQ = 4'b0110;
            #1;
            total++; if (bus.ACK !== 4'b0100) begin bad++; $display("FAIL hold_ack[%0d] got=%b want=0100", b, bus.ACK); end
            tick();
            total++; if (bus.Y !== exp_y) begin bad++; $display("FAIL hold_y[%0d] got=%h want=%h", b, bus.Y, exp_y); end
            total++; if (bus.GNT !== exp_gnt) begin bad++; $display("FAIL hold_gnt[%0d] got=%b want=%b", b, bus.GNT, exp_gnt); end
        end
        #1;
        total++; if (bus.ACK !== 4'b0000) begin bad++; $display("FAIL hold_idle_ack got=%b want=0000", bus.ACK); end
        tick();
        total++; if (bus.GNT !== 4'b0010) begin bad++; $display("FAIL hold_next_gnt got=%b want=0010", bus.GNT); end
        total++; if (bus.SEL !== 2'd1) begin bad++; $display("FAIL hold_next_sel got=%0d want=1", bus.SEL); end
    endtask

    task automatic test_stall;
        logic [31:0] exp_y;
        logic [3:0]  exp_gnt;
        bus.LAST = 4'b0000; bus.D1 = 32'h1111_0000;
        #1;
        total++; if (bus.ACK !== 4'b0010) begin bad++; $display("FAIL stall_ack0 got=%b want=0010", bus.ACK); end
        tick();
        total++; if (bus.Y !== 32'h1111_0000) begin bad++; $display("FAIL stall_y0 got=%h want=11110000", bus.Y); end
        bus.Y_READY = 1'b0; bus.D1 = 32'h1111_0001;
        for (int s = 0; s < 3; s++) begin
            #1;
            total++; if (bus.ACK !== 4'b0000) begin bad++; $display("FAIL stall_ack[%0d] got=%b want=0000", s, bus.ACK); end
            tick();
            total++; if (bus.Y !== 32'h1111_0000) begin bad++; $display("FAIL stall_y[%0d] got=%h want=11110000", s, bus.Y); end
            total++; if (bus.Y_VALID !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b want=1", s, bus.Y_VALID); end
            total++; if (bus.GNT !== 4'b0010) begin bad++; $display("FAIL stall_gnt[%0d] got=%b want=0010", s, bus.GNT); end
        end
        bus.Y_READY = 1'b1;
        for (int b = 1; b < 8; b++) begin
            exp_y   = 32'h1111_0000 + 32'(b);
            exp_gnt = (b == 7) ? 4'b0000 : 4'b0010;
            bus.D1  = exp_y;
            #1;
            total++; if (bus.ACK !== 4'b0010) begin bad++; $display("FAIL resume_ack[%0d] got=%b want=0010", b, bus.ACK); end
            tick();
            total++; if (bus.Y !== exp_y) begin bad++; $display("FAIL resume_y[%0d] got=%h want=%h", b, bus.Y, exp_y); end
            total++; if (bus.GNT !== exp_gnt) begin bad++; $display("FAIL resume_gnt[%0d] got=%b want=%b", b, bus.GNT, exp_gnt); end
        end
        bus.REQ = 4'b1000;
    endtask

    task automatic test_abandon;
        tick();
        total++; if (bus.GNT !== 4'b1000) begin bad++; $display("FAIL abandon_gnt got=%b want=1000", bus.GNT); end
        total++; if (bus.SEL !== 2'd3) begin bad++; $display("FAIL abandon_sel got=%0d want=3", bus.SEL); end
        bus.D3 = 32'h3333_0000;
        #1;
        total++; if (bus.ACK !== 4'b1000) begin bad++; $display("FAIL abandon_ack got=%b want=1000", bus.ACK); end
        tick();
        total++; if (bus.Y !== 32'h3333_0000) begin bad++; $display("FAIL abandon_y got=%h want=33330000", bus.Y); end
        bus.REQ = 4'b0101;
        #1;
        total++; if (bus.ACK !== 4'b0000) begin bad++; $display("FAIL abandon_noack got=%b want=0000", bus.ACK); end
        tick();
        total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL abandon_release got=%b want=0000", bus.GNT); end
        total++; if (bus.Y_VALID !== 1'b0) begin bad++; $display("FAIL abandon_valid got=%b want=0", bus.Y_VALID); end
        total++; if (bus.Y !== 32'h3333_0000) begin bad++; $display("FAIL abandon_yhold got=%h want=33330000", bus.Y); end
        tick();
        total++; if (bus.GNT !== 4'b0001) begin bad++; $display("FAIL abandon_next got=%b want=0001", bus.GNT); end
    endtask

    task automatic test_reset_mid;
        bus.LAST = 4'b0001; bus.D0 = 32'h4444_0000;
        #1;
        total++; if (bus.ACK !== 4'b0001) begin bad++; $display("FAIL rmid_ack0 got=%b want=0001", bus.ACK); end
        tick();
        total++; if (bus.Y !== 32'h4444_0000) begin bad++; $display("FAIL rmid_y0 got=%h want=44440000", bus.Y); end
        tick();
        total++; if (bus.GNT !== 4'b0100) begin bad++; $display("FAIL rmid_gnt2 got=%b want=0100", bus.GNT); end
        total++; if (bus.SEL !== 2'd2) begin bad++; $display("FAIL rmid_sel2 got=%0d want=2", bus.SEL); end
        bus.LAST = 4'b0000; bus.D2 = 32'h5555_0000;
        tick();
        total++; if (bus.Y !== 32'h5555_0000) begin bad++; $display("FAIL rmid_y2 got=%h want=55550000", bus.Y); end
        total++; if (bus.GNT !== 4'b0100) begin bad++; $display("FAIL rmid_busy got=%b want=0100", bus.GNT); end
        rst = 1'b1; bus.Y_READY = 1'b0;
        tick();
        rst = 1'b0;
        total++; if (bus.GNT !== 4'b0000) begin bad++; $display("FAIL rmid_gnt got=%b want=0000", bus.GNT); end
        total++; if (bus.ACK !== 4'b0000) begin bad++; $display("FAIL rmid_ack got=%b want=0000", bus.ACK); end
        total++; if (bus.SEL !== 2'd0) begin bad++; $display("FAIL rmid_sel got=%0d want=0", bus.SEL); end
        total++; if (bus.Y !== 32'h0) begin bad++; $display("FAIL rmid_y got=%h want=0", bus.Y); end
        total++; if (bus.Y_VALID !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", bus.Y_VALID); end
        bus.REQ = 4'b1111; bus.Y_READY = 1'b1;
        tick();
        total++; if (bus.GNT !== 4'b0001) begin bad++; $display("FAIL rmid_first got=%b want=0001", bus.GNT); end
        bus.REQ = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_hold_limit();
        test_stall();
        test_abandon();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
